// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects, memory
// freeze FSM states and stage indices into the valid-bit vector.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int ST_ID  = 0;
  localparam int ST_EX  = 1;
  localparam int ST_MEM = 2;
  localparam int ST_WB  = 3;
  localparam int NSTG   = 4;

  typedef enum logic {M_IDLE = 1'b0, M_WAIT = 1'b1} mem_state_t;

  // The youngest producer (EX/MEM) wins over the older one in MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic hit_mem, input logic hit_wb);
    if (hit_mem) return FWD_MEM;
    if (hit_wb)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Datapath <-> hazard unit bundle: register tags and stage flags in,
// enables, valid bits and forwarding selects out.
interface pipe_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              id_use_rs1, id_use_rs2;
  logic              ex_reg_write, mem_reg_write, wb_reg_write;
  logic              ex_is_load, ex_pc_src, mem_req, mem_ack;
  logic              pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic              v_id, v_ex, v_mem, v_wb;
  logic [1:0]        fwd_a, fwd_b;
  logic              mem_wait;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           id_use_rs1, id_use_rs2, ex_reg_write, mem_reg_write, wb_reg_write,
           ex_is_load, ex_pc_src, mem_req, mem_ack,
    input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           v_id, v_ex, v_mem, v_wb, fwd_a, fwd_b, mem_wait, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           id_use_rs1, id_use_rs2, ex_reg_write, mem_reg_write, wb_reg_write,
           ex_is_load, ex_pc_src, mem_req, mem_ack,
    output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
           v_id, v_ex, v_mem, v_wb, fwd_a, fwd_b, mem_wait, stall_cnt
  );
endinterface

// File: rtl/mem_wait_fsm.sv
// Data-memory freeze tracker: selects external or fixed-latency ack and
// raises mem_wait while a valid access in MEM is still outstanding.
module mem_wait_fsm
  import pipe_pkg::*;
#(
  parameter int ACK_MODE = 1,
  parameter int DMEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic v_mem,
  input  logic mem_req,
  input  logic mem_ack,
  output logic mem_wait
);
  localparam int CW = $clog2(DMEM_LAT + 1) + 1;

  mem_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy, ack_int;

  always_comb begin
    busy     = v_mem & mem_req;
    ack_int  = (ACK_MODE != 0) ? mem_ack : (cnt_q == CW'(DMEM_LAT));
    mem_wait = busy & ~ack_int;
    state_d  = state_q;
    unique case (state_q)
      M_IDLE:  if (mem_wait) state_d = M_WAIT;
      // Leaving on !mem_wait covers the ack and a request that vanished.
      M_WAIT:  if (!mem_wait) state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
    cnt_d = (state_d == M_WAIT && ACK_MODE == 0) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= M_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and stall controller for the 5-stage RV32I pipe; owns the
// stage valid bits and drives register enables and EX operand selects.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int FWD_EN   = 1,
  parameter int ACK_MODE = 1,
  parameter int DMEM_LAT = 2,
  parameter int CNT_W    = 32
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_unit_if.slave bus
);
  logic [NSTG-1:0]  vld_q, vld_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [NSTG-1:1]  rs1_hit, rs2_hit;
  logic             mem_wait, redirect, load_use, raw_dep, hz_stall;
  logic             pc_en, en_ifid, en_idex, en_exmem, en_memwb;

  function automatic logic prod(input logic v, input logic we,
                                input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return v & we & (rd != '0) & (rd == rs);
  endfunction

  mem_wait_fsm #(.ACK_MODE(ACK_MODE), .DMEM_LAT(DMEM_LAT)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .v_mem   (vld_q[ST_MEM]),
    .mem_req (bus.mem_req),
    .mem_ack (bus.mem_ack),
    .mem_wait(mem_wait)
  );

  always_comb begin
    rs1_hit[ST_EX]  = prod(vld_q[ST_EX],  bus.ex_reg_write,  bus.ex_rd,  bus.id_rs1);
    rs1_hit[ST_MEM] = prod(vld_q[ST_MEM], bus.mem_reg_write, bus.mem_rd, bus.id_rs1);
    rs1_hit[ST_WB]  = prod(vld_q[ST_WB],  bus.wb_reg_write,  bus.wb_rd,  bus.id_rs1);
    rs2_hit[ST_EX]  = prod(vld_q[ST_EX],  bus.ex_reg_write,  bus.ex_rd,  bus.id_rs2);
    rs2_hit[ST_MEM] = prod(vld_q[ST_MEM], bus.mem_reg_write, bus.mem_rd, bus.id_rs2);
    rs2_hit[ST_WB]  = prod(vld_q[ST_WB],  bus.wb_reg_write,  bus.wb_rd,  bus.id_rs2);

    load_use = vld_q[ST_ID] & vld_q[ST_EX] & bus.ex_is_load &
               ((bus.id_use_rs1 & rs1_hit[ST_EX]) | (bus.id_use_rs2 & rs2_hit[ST_EX]));
    raw_dep  = vld_q[ST_ID] & ((bus.id_use_rs1 & (|rs1_hit)) | (bus.id_use_rs2 & (|rs2_hit)));
    hz_stall = load_use | ((FWD_EN == 0) && raw_dep);
    redirect = vld_q[ST_EX] & bus.ex_pc_src;

    pc_en    = 1'b1;
    en_ifid  = 1'b1;
    en_idex  = 1'b1;
    en_exmem = 1'b1;
    en_memwb = 1'b1;
    vld_d    = {vld_q[ST_MEM:ST_ID], 1'b1};
    if (mem_wait) begin
      // Everything upstream of MEM/WB holds; WB drains and receives a bubble.
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      vld_d    = {1'b0, vld_q[ST_MEM:ST_ID]};
    end else if (redirect) begin
      vld_d    = {vld_q[ST_MEM:ST_EX], 2'b00};
    end else if (hz_stall) begin
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      vld_d    = {vld_q[ST_MEM:ST_EX], 1'b0, vld_q[ST_ID]};
    end

    stall_cnt_d = (!pc_en && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;

    bus.fwd_a = FWD_RF;
    bus.fwd_b = FWD_RF;
    if (FWD_EN != 0) begin
      bus.fwd_a = fwd_sel(prod(vld_q[ST_MEM], bus.mem_reg_write, bus.mem_rd, bus.ex_rs1),
                          prod(vld_q[ST_WB],  bus.wb_reg_write,  bus.wb_rd,  bus.ex_rs1));
      bus.fwd_b = fwd_sel(prod(vld_q[ST_MEM], bus.mem_reg_write, bus.mem_rd, bus.ex_rs2),
                          prod(vld_q[ST_WB],  bus.wb_reg_write,  bus.wb_rd,  bus.ex_rs2));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      vld_q       <= vld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.en_ifid   = en_ifid;
  assign bus.en_idex   = en_idex;
  assign bus.en_exmem  = en_exmem;
  assign bus.en_memwb  = en_memwb;
  assign bus.v_id      = vld_q[ST_ID];
  assign bus.v_ex      = vld_q[ST_EX];
  assign bus.v_mem     = vld_q[ST_MEM];
  assign bus.v_wb      = vld_q[ST_WB];
  assign bus.mem_wait  = mem_wait;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Three configurations driven by shared stimulus: k0 forwarding/ext ack,
// k1 stall-only/ext ack, k2 forwarding/internal 2-cycle ack.
module tb_pipe_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_reg_write, mem_reg_write, wb_reg_write;
  logic ex_is_load, ex_pc_src, mem_req, mem_ack;

  // obs bits: 13 pc_en,12 ifid,11 idex,10 exmem,9 memwb,8:7 fwd_a,6:5 fwd_b,4 mem_wait,3:0 {wb,mem,ex,id}
  logic [2:0][13:0] obs;
  logic [2:0][31:0] obs_cnt;

  for (genvar g = 0; g < 3; g++) begin : gi
    pipe_hazard_unit_if #(.REG_AW(5), .CNT_W(32)) b ();
    assign b.id_rs1 = id_rs1;               assign b.id_rs2 = id_rs2;
    assign b.ex_rs1 = ex_rs1;               assign b.ex_rs2 = ex_rs2;
    assign b.ex_rd = ex_rd;                 assign b.mem_rd = mem_rd;
    assign b.wb_rd = wb_rd;                 assign b.id_use_rs1 = id_use_rs1;
    assign b.id_use_rs2 = id_use_rs2;       assign b.ex_reg_write = ex_reg_write;
    assign b.mem_reg_write = mem_reg_write; assign b.wb_reg_write = wb_reg_write;
    assign b.ex_is_load = ex_is_load;       assign b.ex_pc_src = ex_pc_src;
    assign b.mem_req = mem_req;             assign b.mem_ack = mem_ack;
    pipe_hazard_unit #(.REG_AW(5), .FWD_EN(g == 1 ? 0 : 1), .ACK_MODE(g == 2 ? 0 : 1),
                       .DMEM_LAT(2), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(b));
    assign obs[g] = {b.pc_en, b.en_ifid, b.en_idex, b.en_exmem, b.en_memwb, b.fwd_a, b.fwd_b,
                     b.mem_wait, b.v_wb, b.v_mem, b.v_ex, b.v_id};
    assign obs_cnt[g] = b.stall_cnt;
  end

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  // Reference model: which instruction slots hold live work, per configuration.
  bit live_id [3], live_ex [3], live_mem [3], live_wb [3];
  int frozen_for [3];
  int stalls [3];

  function automatic bit fwd_on(int k); return k != 1; endfunction
  function automatic bit ext_ack(int k); return k != 2; endfunction

  // Does a live instruction in stage s (1=EX,2=MEM,3=WB) write register r?
  function automatic bit writes(int k, int s, logic [4:0] r);
    if (r == 5'd0) return 0;
    case (s)
      1: return live_ex[k] && ex_reg_write && ex_rd == r;
      2: return live_mem[k] && mem_reg_write && mem_rd == r;
      default: return live_wb[k] && wb_reg_write && wb_rd == r;
    endcase
  endfunction

  function automatic logic [1:0] fwd_src(int k, logic [4:0] r);
    if (!fwd_on(k)) return 2'd0;
    if (writes(k, 2, r)) return 2'd2;
    if (writes(k, 3, r)) return 2'd1;
    return 2'd0;
  endfunction

  // mode: 0 advance, 1 data stall, 2 redirect, 3 memory freeze
  function automatic int mode_of(int k);
    bit needs_ex, needs_any;
    if (live_mem[k] && mem_req && (ext_ack(k) ? !mem_ack : frozen_for[k] < 2)) return 3;
    if (live_ex[k] && ex_pc_src) return 2;
    needs_ex = (id_use_rs1 && writes(k, 1, id_rs1)) || (id_use_rs2 && writes(k, 1, id_rs2));
    needs_any = 0;
    for (int s = 1; s <= 3; s++)
      if ((id_use_rs1 && writes(k, s, id_rs1)) || (id_use_rs2 && writes(k, s, id_rs2))) needs_any = 1;
    if (live_id[k] && live_ex[k] && ex_is_load && needs_ex) return 1;
    if (live_id[k] && !fwd_on(k) && needs_any) return 1;
    return 0;
  endfunction

  function automatic logic [13:0] expect_out(int k);
    logic [4:0] en;
    case (mode_of(k))
      3: en = 5'b00001;
      1: en = 5'b00111;
      default: en = 5'b11111;
    endcase
    return {en, fwd_src(k, ex_rs1), fwd_src(k, ex_rs2), (mode_of(k) == 3),
            live_wb[k], live_mem[k], live_ex[k], live_id[k]};
  endfunction

  function automatic void model_clock();
    for (int k = 0; k < 3; k++) begin
      int m;
      m = mode_of(k);
      if (!rst) begin
        live_id[k] = 0; live_ex[k] = 0; live_mem[k] = 0; live_wb[k] = 0;
        frozen_for[k] = 0; stalls[k] = 0;
      end else begin
        if (m == 1 || m == 3) stalls[k] = stalls[k] + 1;
        frozen_for[k] = (m == 3) ? frozen_for[k] + 1 : 0;
        if (m == 3) live_wb[k] = 0;
        else begin
          live_wb[k]  = live_mem[k];
          live_mem[k] = live_ex[k];
          live_ex[k]  = (m == 0) ? live_id[k] : 0;
          live_id[k]  = (m == 0) ? 1 : (m == 1) ? live_id[k] : 0;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    if (chk_on)
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_out[%0d]", k), 32'(obs[k]), 32'(expect_out(k)));
        chk($sformatf("model_cnt[%0d]", k), obs_cnt[k], 32'(stalls[k]));
      end
  endtask

  task automatic adv();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic quiet();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_is_load = 0; ex_pc_src = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic refill(input int n);
    quiet();
    for (int i = 0; i < n; i++) begin settle(); adv(); end
  endtask

  initial begin
    int raw_stalls;
    quiet();
    rst = 0;
    adv();
    chk_on = 1;
    settle();
    chk("rst_valid", 32'(obs[0][3:0]), 32'd0);
    chk("rst_enables", 32'(obs[0][13:9]), 32'h1f);
    chk("rst_fwd", 32'(obs[0][8:5]), 32'd0);
    chk("rst_mem_wait", 32'(obs[0][4]), 32'd0);
    chk("rst_cnt", obs_cnt[0], 32'd0);
    adv();
    rst = 1;
    for (int i = 0; i <= 4; i++) begin
      settle();
      chk($sformatf("fill%0d", i), 32'(obs[0][3:0]), (32'd1 << i) - 32'd1);
      chk($sformatf("fill_cnt%0d", i), obs_cnt[0], 32'd0);
      adv();
    end

    // load-use: lw x5 in EX, ID reads x5
    ex_is_load = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    settle();
    chk("lu_pc_en", 32'(obs[0][13]), 32'd0);
    chk("lu_en_ifid", 32'(obs[0][12]), 32'd0);
    chk("lu_en_idex", 32'(obs[0][11]), 32'd1);
    adv();
    quiet();
    settle();
    chk("lu_bubble", 32'(obs[0][1]), 32'd0);
    chk("lu_resume", 32'(obs[0][13]), 32'd1);
    chk("lu_cnt", obs_cnt[0], 32'd1);
    adv();
    refill(4);

    // forwarding selects on ex_rs1/ex_rs2 = x3
    quiet(); ex_rs1 = 3; ex_rs2 = 3; mem_reg_write = 1; mem_rd = 3;
    settle();
    chk("fwd_a_mem", 32'(obs[0][8:7]), 32'd2);
    chk("fwd_b_mem", 32'(obs[0][6:5]), 32'd2);
    chk("fwd_a_off", 32'(obs[1][8:7]), 32'd0);
    adv();
    wb_reg_write = 1; wb_rd = 3;
    settle();
    chk("fwd_a_prio", 32'(obs[0][8:7]), 32'd2);
    adv();
    mem_reg_write = 0;
    settle();
    chk("fwd_a_wb", 32'(obs[0][8:7]), 32'd1);
    adv();
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0;
    settle();
    chk("fwd_a_x0", 32'(obs[0][8:7]), 32'd0);
    adv();
    refill(4);

    // FWD_EN=0: producer x7 walks EX -> MEM -> WB while ID reads x7 as rs2
    raw_stalls = 0;
    for (int s = 0; s < 4; s++) begin
      quiet(); id_rs2 = 7; id_use_rs2 = 1; ex_rs2 = 7;
      ex_rd = 7; mem_rd = 7; wb_rd = 7;
      ex_reg_write = (s == 0); mem_reg_write = (s == 1); wb_reg_write = (s == 2);
      settle();
      if (obs[1][13] == 1'b0) raw_stalls++;
      chk($sformatf("raw_fwd_b%0d", s), 32'(obs[1][6:5]), 32'd0);
      if (s == 3) chk("raw_release", 32'(obs[1][12]), 32'd1);
      adv();
    end
    chk("raw_stalls", 32'(raw_stalls), 32'd3);
    refill(4);

    // redirect together with a load-use match
    quiet(); ex_pc_src = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    settle();
    chk("redir_pc_en", 32'(obs[0][13]), 32'd1);
    chk("redir_pc_en_k1", 32'(obs[1][13]), 32'd1);
    adv();
    quiet();
    settle();
    chk("redir_flush", 32'(obs[0][1:0]), 32'd0);
    chk("redir_branch_mem", 32'(obs[0][2]), 32'd1);
    chk("redir_cnt", obs_cnt[0], 32'd1);
    adv();
    refill(4);

    // memory freeze: internal 2-cycle ack on k2, external ack on k0
    for (int c = 0; c < 3; c++) begin
      quiet(); mem_req = 1; mem_ack = (c == 2);
      settle();
      chk($sformatf("mw_k2_%0d", c), 32'(obs[2][4]), (c < 2) ? 32'd1 : 32'd0);
      chk($sformatf("mw_k0_%0d", c), 32'(obs[0][4]), (c < 2) ? 32'd1 : 32'd0);
      if (c < 2) chk($sformatf("mw_en_%0d", c), 32'(obs[2][13:9]), 32'h01);
      adv();
    end
    refill(4);

    // reset during the wait
    quiet(); mem_req = 1;
    settle();
    chk("mwr_wait", 32'(obs[2][4]), 32'd1);
    adv();
    rst = 0;
    settle();
    chk("mwr_wait2", 32'(obs[2][4]), 32'd1);
    adv();
    rst = 1;
    settle();
    chk("mwr_valid", 32'(obs[2][3:0]), 32'd0);
    chk("mwr_idle", 32'(obs[2][4]), 32'd0);
    chk("mwr_en", 32'(obs[2][13:9]), 32'h1f);
    adv();
    refill(4);

    for (int n = 0; n < 400; n++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));  mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
      ex_reg_write = 1'($urandom_range(0, 1)); mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write = 1'($urandom_range(0, 1)); ex_is_load = 1'($urandom_range(0, 1));
      ex_pc_src = ($urandom_range(0, 7) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ack = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 49) != 0);
      settle();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard, forwarding and stall controller for the 5-stage RV32I pipeline datapath. It owns the valid bits of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and issues per-stage enables. It detects load-use and RAW hazards and selects EX-stage forwarding sources. It also flushes on EX-stage redirects and freezes the pipe while a data-memory access is outstanding. It sits beside the datapath, and its outputs drive the pipeline-register enables and the ALU operand muxes.

## Interface
Parameters:
- REG_AW, 5, register address width
- FWD_EN, 1, 1 = forwarding enabled; 0 = resolve every RAW hazard by stalling
- ACK_MODE, 1, 1 = use external mem_ack; 0 = internal fixed-latency ack
- DMEM_LAT, 2, internal ack latency in cycles (ACK_MODE=0); 0 = no wait
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1 / rs2
- ex_rs1, ex_rs2  in  REG_AW  sources held in ID/EX
- ex_rd, mem_rd, wb_rd  in  REG_AW  destinations held in ID/EX, EX/MEM, MEM/WB
- ex_reg_write, mem_reg_write, wb_reg_write  in  1  stage writes the register file
- ex_is_load  in  1  ID/EX holds a load
- ex_pc_src  in  1  branch taken / jump resolved in EX
- mem_req  in  1  EX/MEM holds a memory access
- mem_ack  in  1  memory completes the access this cycle
- pc_en, en_ifid, en_idex, en_exmem, en_memwb  out  1  register load enables
- v_id, v_ex, v_mem, v_wb  out  1  stage valid bits; downstream gates writes with these
- fwd_a, fwd_b  out  2  EX operand source: 00 register file, 01 WB result, 10 EX/MEM alu_out
- mem_wait  out  1  memory freeze active
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
- Producer match for a stage: v_stage & stage_reg_write & stage_rd≠0 & stage_rd equals the source register.
- Load-use (any FWD_EN): v_id & v_ex & ex_is_load & EX match on a used ID source. Response: pc_en=en_ifid=0, en_idex=1, v_ex next=0 (bubble).
- FWD_EN=0: a match of a used ID source against EX, MEM or WB triggers the same stall-and-bubble response; fwd_a/fwd_b are held at 00.
- FWD_EN=1 forwarding is evaluated per operand on ex_rs1/ex_rs2. The MEM match (10) has priority over the WB match (01); otherwise the select is 00.
- Redirect: v_ex & ex_pc_src. Response: pc_en=1, next v_id=0 and v_ex=0 (flush both younger stages). The redirect overrides any load-use or RAW stall in the same cycle.
- Memory FSM, states M_IDLE and M_WAIT:
  - ack_int = mem_ack when ACK_MODE=1; otherwise asserted when the wait counter reaches DMEM_LAT, or immediately when DMEM_LAT=0.
  - M_IDLE → M_WAIT when v_mem & mem_req & !ack_int.
  - M_WAIT → M_IDLE when ack_int.
  - mem_wait = (v_mem & mem_req & !ack_int).
- While mem_wait=1: all enables are 0 except en_memwb=1, and v_wb next=0. Redirects and hazards are held, not acted on, until the freeze ends.
- Priority: mem_wait > redirect > data-hazard stall > advance.
- Valid bits advance with their enables: v_id←1 when en_ifid is set and there is no flush.
- stall_cnt increments on every cycle with pc_en=0 and saturates at all-ones.

## Timing
- Reset (rst=0 at a clk edge): all v_* = 0, FSM in M_IDLE, wait counter 0, stall_cnt 0. Consequently fwd_a = fwd_b = 00, mem_wait=0, and all enables are 1.
- All outputs except the state (valid bits, FSM, counters) are combinational from the current state and inputs within the same cycle.
- Latencies:
  - Load-use costs exactly 1 bubble.
  - With FWD_EN=0, a dependent instruction waits until its producer has left WB: up to 3 bubbles.
  - Redirect penalty is 2 cycles.
  - Internal-ack access with DMEM_LAT=N freezes the pipe for N cycles.
- Reset asserted mid-wait returns the FSM to M_IDLE and drops all valid bits on the same edge.
- rd=x0 never produces a hazard or a forward.

## Structure
- Shared package pipe_pkg holds:
  - forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - mem_state_t enum {M_IDLE, M_WAIT}.
- Sub-module mem_wait_fsm contains the FSM, the latency counter and the ACK_MODE selection, and outputs mem_wait.

## Test plan
- Reset, then 4 free-running cycles → v_id,v_ex,v_mem,v_wb become 1 on successive cycles; stall_cnt=0.
- lw x5 in EX, ID reads x5 → exactly one cycle with pc_en=0 and en_ifid=0; v_ex=0 on the next cycle; stall_cnt=1.
- FWD_EN=1, add x3 in MEM and ex_rs1=3 → fwd_a=10. Same x3 also in WB → fwd_a remains 10. Producer rd=0 → fwd_a=00.
- FWD_EN=0, ex_rd=7 writing and id_rs2=7 → 3 stall cycles before en_ifid=1; fwd_b stays 00.
- ex_pc_src=1 simultaneous with a load-use match → pc_en=1; v_id=v_ex=0 on the next cycle; no stall cycle counted.
- ACK_MODE=0, DMEM_LAT=2, mem_req in MEM → mem_wait=1 for 2 cycles with all enables 0. Assert rst during the wait → FSM in M_IDLE and all v_* = 0 on the next cycle.
